// File: rtl/lock_pkg.sv
// Shared types and defaults for the XOR-lock key loader.
// LOCK_KEY_PARITY_EN adds an even-parity bit to the serial frame.
package lock_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCheck,
        StCommit,
        StSettle
    } key_ld_state_t;

    localparam int unsigned LOCK_KEY_W      = 16;
    localparam int unsigned LOCK_SETTLE_CYC = 4;

`ifdef LOCK_KEY_PARITY_EN
    localparam bit LOCK_PAR_EN = 1'b1;
`else
    localparam bit LOCK_PAR_EN = 1'b0;
`endif

    function automatic int unsigned frame_len(input int unsigned key_w, input bit par_en);
        return par_en ? key_w + 1 : key_w;
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Shadow key register with saturating bit counter and running parity.
// Only the first KEY_W bits shift into the key; a parity bit only updates par.
module key_shift_reg #(
    parameter int unsigned KEY_W   = 16,
    parameter int unsigned FRAME_N = 16,
    parameter int unsigned CNT_W   = $clog2(KEY_W + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [KEY_W-1:0] data,
    output logic [CNT_W-1:0] count,
    output logic             par
);

    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_N);
    localparam logic [CNT_W-1:0] KEY_C   = CNT_W'(KEY_W);

    logic [KEY_W-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_count <= '0;
            r_par   <= 1'b0;
        end else if (clr) begin
            r_data  <= '0;
            r_count <= '0;
            r_par   <= 1'b0;
        end else if (shift_en && (r_count != FRAME_C)) begin
            if (r_count < KEY_C) begin
                r_data <= {din, r_data[KEY_W-1:1]};
            end
            r_count <= r_count + 1'b1;
            r_par   <= r_par ^ din;
        end
    end

    assign data  = r_data;
    assign count = r_count;
    assign par   = r_par;

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader: assembles a key, commits it atomically, then holds key_valid low to settle.
// Define LOCK_KEY_PARITY_EN to enable the even-parity frame bit and the err pulse.
module lock_key_loader
    import lock_pkg::*;
#(
    parameter int unsigned KEY_W      = LOCK_KEY_W,
    parameter int unsigned SETTLE_CYC = LOCK_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             load_abort,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int unsigned      FRAME_N     = frame_len(KEY_W, LOCK_PAR_EN);
    localparam int unsigned      CNT_W       = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(FRAME_N - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);

    key_ld_state_t    r_state;
    key_ld_state_t    w_state_next;
    logic [KEY_W-1:0] r_key;
    logic             r_key_valid;
    logic [7:0]       r_settle;

    logic             w_clr;
    logic             w_shift_en;
    logic             w_par_ok;
    logic [KEY_W-1:0] w_data;
    logic [CNT_W-1:0] w_count;
    logic             w_par;

    key_shift_reg #(
        .KEY_W   (KEY_W),
        .FRAME_N (FRAME_N),
        .CNT_W   (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_clr),
        .shift_en (w_shift_en),
        .din      (sin_data),
        .data     (w_data),
        .count    (w_count),
        .par      (w_par)
    );

`ifdef LOCK_KEY_PARITY_EN
    assign w_par_ok = ~w_par;
    assign err      = (r_state == StCheck) && !w_par_ok;
`else
    logic w_unused_par;
    assign w_unused_par = w_par;
    assign w_par_ok     = 1'b1;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clr        = 1'b0;
        w_shift_en   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clr = 1'b1;
                if (load_start) begin
                    w_state_next = StShift;
                end
            end
            StShift: begin
                // Abort wins over a bit arriving in the same cycle.
                if (load_abort) begin
                    w_state_next = StIdle;
                end else if (sin_valid) begin
                    w_shift_en = 1'b1;
                    if (w_count == LAST_BIT) begin
                        w_state_next = StCheck;
                    end
                end
            end
            StCheck: begin
                w_state_next = w_par_ok ? StCommit : StIdle;
            end
            StCommit: begin
                w_state_next = StSettle;
            end
            StSettle: begin
                if (r_settle == 8'd0) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_settle    <= 8'd0;
        end else if (r_state == StCommit) begin
            r_key       <= w_data;
            r_key_valid <= 1'b0;
            r_settle    <= SETTLE_INIT;
        end else if (r_state == StSettle) begin
            if (r_settle == 8'd0) begin
                r_key_valid <= 1'b1;
            end else begin
                r_settle <= r_settle - 8'd1;
            end
        end
    end

    assign sin_ready = (r_state == StShift);
    assign busy      = (r_state != StIdle);
    assign key_out   = r_key;
    assign key_valid = r_key_valid;

endmodule
